dmem_lsu: RTL and testbench

Load/store unit plus word-organised data memory. It sits directly downstream of the CPU MEM stage and consumes mem_r, mem_w, Addr_out, Data_out and the per-access DMType. It performs byte-lane steering and byte-enable writes, and sign- or zero-extends loads. It models a configurable wait-state memory and holds the pipeline with a stall request until each access completes.

---
 rtl/dmem_lsu_pkg.sv | 17 +
 rtl/dmem_lsu_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 80 ++++++++
 rtl/dmem_lsu.sv | 137 +++++++++++++
 tb/tb_dmem_lsu.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: dm_type access
// codes driven by the MEM stage and the LSU sequencer state encoding.
package ctrl_encode_def;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// MEM-stage <-> load/store unit bus. The master is the CPU MEM stage,
// the slave is dmem_lsu.
interface dmem_lsu_if;

  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic        done;
  logic        stall_req;
  logic        misalign;

  modport master (
    output mem_r, mem_w, addr, wdata, dm_type,
    input  rdata, done, stall_req, misalign
  );

  modport slave (
    input  mem_r, mem_w, addr, wdata, dm_type,
    output rdata, done, stall_req, misalign
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the LSU (combinational). Produces the store
// byte enables and replicated store data, and extracts/extends load data.
// With DMEM_MISALIGN_CHECK_EN defined, misaligned half/word accesses are
// flagged and suppressed (no lanes enabled, load data forced to zero).
module dmem_lane_align
  import ctrl_encode_def::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        misalign
);

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] v);
    return {24'd0, v};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        is_half;
  logic        is_byte;

  // Lane selection, store steering and load extension by access size
  always_comb begin
    be       = 4'hF;
    wword    = wdata;
    ldata    = rword;
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    byte_sel = rword[{addr_lo, 3'b000} +: 8];
    is_half  = 1'b0;
    is_byte  = 1'b0;
    misalign = 1'b0;
    case (dm_type)
      dm_halfword, dm_halfword_unsigned: begin
        is_half = 1'b1;
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
        ldata   = (dm_type == dm_halfword) ? sext16(half_sel) : zext16(half_sel);
      end
      dm_byte, dm_byte_unsigned: begin
        is_byte = 1'b1;
        be      = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        ldata   = (dm_type == dm_byte) ? sext8(byte_sel) : zext8(byte_sel);
      end
      default: begin
        // word, and any undefined encoding
        be    = 4'hF;
        wword = wdata;
        ldata = rword;
      end
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = is_half ? addr_lo[0] : (!is_byte && (addr_lo != 2'b00));
    if (misalign) begin
      be    = 4'h0;
      ldata = '0;
    end
`else
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit with word-organised data memory and a programmable
// number of wait states. Each access is held with stall_req until the
// one-cycle done pulse. Optional macro: DMEM_MISALIGN_CHECK_EN enables
// misaligned-access detection (misalign pulse, access suppressed).
module dmem_lsu
  import ctrl_encode_def::*;
#(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 1
)
(
  input  logic      clk,
  input  logic      reset,
  dmem_lsu_if.slave bus
);

  lsu_state_e state_q;
  lsu_state_e state_d;
  logic [3:0] count_q;
  logic       accept;
  logic       commit;
  logic       stall;
  logic       done_c;
  logic       req;

  logic [AW+1:0] addr_p0;
  logic [31:0]   wdata_p0;
  logic [2:0]    type_p0;
  logic          write_p0;

  logic [31:0] mem [DEPTH];
  logic [31:0] rword;
  logic [31:0] wword;
  logic [31:0] ldata;
  logic [3:0]  be;
  logic        mis;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic [AW-1:0] idx;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign req   = bus.mem_r | bus.mem_w;
  assign idx   = addr_p0[AW+1:2];
  assign rword = mem[idx];

  dmem_lane_align u_align (
    .dm_type  (type_p0),
    .addr_lo  (addr_p0[1:0]),
    .wdata    (wdata_p0),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .ldata    (ldata),
    .misalign (mis)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall   = 1'b1;
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (count_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // requests seen here belong to the instruction being released
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait-state counter, load result and misalign pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept)                                  count_q <= 4'(WAIT_CYCLES);
      else if (state_q == ST_BUSY && count_q != 0) count_q <= count_q - 4'd1;
      mis_q <= commit & mis;
      if (commit) rdata_q <= write_p0 ? 32'd0 : ldata;
    end
  end

  // ---- request capture (p0) ----
  // Capture the access when it is accepted in IDLE; store wins over load
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= bus.addr[AW+1:0];
      wdata_p0 <= bus.wdata;
      type_p0  <= bus.dm_type;
      write_p0 <= bus.mem_w;
    end
  end

  // ---- memory commit ----
  // Byte-enabled store into the array on the final wait-state edge
  always_ff @(posedge clk) begin
    if (commit && write_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.stall_req = reset & stall;
  assign bus.done      = done_c;
  assign bus.rdata     = rdata_q;
  assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu (WAIT_CYCLES=1): a table of load/store
// vectors with hand-computed results, plus sequences for reset, request
// overlap with DONE, and the DMEM_MISALIGN_CHECK_EN option.
module tb_dmem_lsu;
  import ctrl_encode_def::*;

  localparam int WAITC = 1;
  localparam int LAT   = WAITC + 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   mis_cnt = 0;

  dmem_lsu_if bif ();

  dmem_lsu #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WAITC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.done)     done_cnt++;
    if (bif.misalign) mis_cnt++;
  end

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  t;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] t, input logic hold,
                        output logic [31:0] rd, output int lat, output int stall_cycles,
                        output logic mis_seen, output logic timed_out);
    lat = 0; stall_cycles = 0; mis_seen = 1'b0; timed_out = 1'b0; rd = '0;
    @(negedge clk);
    bif.mem_r = r; bif.mem_w = w; bif.addr = a; bif.wdata = d; bif.dm_type = t;
    #1;
    if (bif.stall_req) stall_cycles++;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bif.done) begin
        rd = bif.rdata;
        mis_seen = bif.misalign;
        if (bif.stall_req) stall_cycles += 100;
        break;
      end
      if (bif.stall_req) stall_cycles++;
      if (lat >= 40) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (!hold) begin bif.mem_r = 1'b0; bif.mem_w = 1'b0; end
    @(negedge clk);
    bif.mem_r = 1'b0; bif.mem_w = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat, stc, d0, m0;
  logic        mis_seen, to;

  initial begin
    vecs[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, dm_word,              32'h0000_0000};
    vecs[1]  = '{1, 0, 32'h0000_0010, 32'h0,         dm_word,              32'hDEAD_BEEF};
    vecs[2]  = '{0, 1, 32'h0000_0020, 32'h80FF_7F01, dm_word,              32'h0000_0000};
    vecs[3]  = '{1, 0, 32'h0000_0023, 32'h0,         dm_byte,              32'hFFFF_FF80};
    vecs[4]  = '{1, 0, 32'h0000_0023, 32'h0,         dm_byte_unsigned,     32'h0000_0080};
    vecs[5]  = '{1, 0, 32'h0000_0020, 32'h0,         dm_halfword,          32'h0000_7F01};
    vecs[6]  = '{1, 0, 32'h0000_0022, 32'h0,         dm_halfword_unsigned, 32'h0000_80FF};
    vecs[7]  = '{1, 0, 32'h0000_0022, 32'h0,         dm_halfword,          32'hFFFF_80FF};
    vecs[8]  = '{1, 0, 32'h0000_0020, 32'h0,         dm_byte,              32'h0000_0001};
    vecs[9]  = '{0, 1, 32'h0000_0024, 32'h1122_3344, dm_word,              32'h0000_0000};
    vecs[10] = '{0, 1, 32'h0000_0025, 32'hFFFF_FFAA, dm_byte,              32'h0000_0000};
    vecs[11] = '{1, 0, 32'h0000_0024, 32'h0,         dm_word,              32'h1122_AA44};
    vecs[12] = '{0, 1, 32'h0000_0026, 32'h9999_5566, dm_halfword,          32'h0000_0000};
    vecs[13] = '{1, 0, 32'h0000_0024, 32'h0,         dm_word,              32'h5566_AA44};
    vecs[14] = '{1, 0, 32'h0000_0024, 32'h0,         3'b111,               32'h5566_AA44};
    vecs[15] = '{1, 0, 32'h0000_0027, 32'h0,         dm_byte_unsigned,     32'h0000_0055};
    vecs[16] = '{0, 1, 32'h0000_0030, 32'hCAFE_F00D, dm_word,              32'h0000_0000};
    vecs[17] = '{1, 0, 32'hFFFF_1010, 32'h0,         dm_word,              32'hDEAD_BEEF};

    // reset with a request pending: stall must stay low
    reset = 1'b0;
    bif.mem_r = 1'b1; bif.mem_w = 1'b0; bif.addr = '0; bif.wdata = '0; bif.dm_type = dm_word;
    repeat (2) @(negedge clk);
    check("reset_stall", {31'd0, bif.stall_req}, 32'd0);
    check("reset_done",  {31'd0, bif.done},      32'd0);
    check("reset_rdata", bif.rdata,              32'd0);
    check("reset_mis",   {31'd0, bif.misalign},  32'd0);
    bif.mem_r = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // first store: latency and stall profile
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    check("first_timeout", {31'd0, to}, 32'd0);
    check("first_latency", lat, LAT);
    check("first_stall_cycles", stc, LAT);

    for (int i = 0; i < 18; i++) begin
      access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].t, 1'b0, rd, lat, stc, mis_seen, to);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // reset while BUSY during a store: nothing committed, no done
    d0 = done_cnt;
    @(negedge clk);
    bif.mem_w = 1'b1; bif.mem_r = 1'b0; bif.addr = 32'h30; bif.wdata = 32'h1234_5678; bif.dm_type = dm_word;
    @(negedge clk);
    reset = 1'b0;
    bif.mem_w = 1'b0;
    #1;
    check("abort_done",  {31'd0, bif.done},      32'd0);
    check("abort_stall", {31'd0, bif.stall_req}, 32'd0);
    check("abort_rdata", bif.rdata,              32'd0);
    check("abort_mis",   {31'd0, bif.misalign},  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done_pulse", done_cnt - d0, 0);
    access(1'b1, 1'b0, 32'h30, 32'h0, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    check("abort_word_unchanged", rd, 32'hCAFE_F00D);

    // both requests held through DONE: one store, one done pulse
    d0 = done_cnt;
    access(1'b1, 1'b1, 32'h50, 32'h7777_7777, dm_word, 1'b1, rd, lat, stc, mis_seen, to);
    check("both_rdata_store", rd, 32'd0);
    repeat (5) @(negedge clk);
    check("both_one_done", done_cnt - d0, 1);
    check("both_idle_stall", {31'd0, bif.stall_req}, 32'd0);
    access(1'b1, 1'b0, 32'h50, 32'h0, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    check("both_was_store", rd, 32'h7777_7777);
    check("both_next_latency", lat, LAT);

    // misaligned word store to 0x41 over 0x0BADF00D at 0x40
    access(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    m0 = mis_cnt;
    access(1'b0, 1'b1, 32'h41, 32'h1111_2222, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    check("mis_store_latency", lat, LAT);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_flag_at_done", {31'd0, mis_seen}, 32'd1);
    check("mis_pulse_count", mis_cnt - m0, 1);
    access(1'b1, 1'b0, 32'h40, 32'h0, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    check("mis_mem_unchanged", rd, 32'h0BAD_F00D);
    access(1'b1, 1'b0, 32'h41, 32'h0, dm_halfword, 1'b0, rd, lat, stc, mis_seen, to);
    check("mis_load_zero", rd, 32'h0);
`else
    check("mis_flag_at_done", {31'd0, mis_seen}, 32'd0);
    check("mis_pulse_count", mis_cnt - m0, 0);
    access(1'b1, 1'b0, 32'h40, 32'h0, dm_word, 1'b0, rd, lat, stc, mis_seen, to);
    check("mis_mem_written", rd, 32'h1111_2222);
    access(1'b1, 1'b0, 32'h41, 32'h0, dm_halfword, 1'b0, rd, lat, stc, mis_seen, to);
    check("half_ignores_a0", rd, 32'h0000_2222);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
